xfer_sequencer: RTL and testbench

//  Sequences one frame through the byte-to-word data-transfer FSM (top_fsm).
//  - Takes a 32-byte valid/ready input stream and writes it into the datapath.
//  - Pulses op_mode once the frame is loaded, then waits for done.
//  - Reads the 16 packed words back out as a 16-bit valid/ready output stream.

---
 rtl/xfer_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_xfer_sequencer.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xfer_sequencer.sv
// Frame sequencer around the byte-to-word datapath: loads N_BYTES bytes, starts
// the packer, waits for done, then streams the N_BYTES/2 packed words back out.
module xfer_sequencer #(
  parameter int N_BYTES      = 32,
  parameter int DONE_TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       abort,
  input  logic                       in_valid,
  input  logic [7:0]                 in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [15:0]                out_data,
  input  logic                       out_ready,
  output logic                       fsm_wr_en,
  output logic [$clog2(N_BYTES)-1:0] fsm_wr_add,
  output logic [7:0]                 fsm_data_wr,
  output logic                       fsm_op_mode,
  output logic [$clog2(N_BYTES)-2:0] fsm_rd_add,
  input  logic [15:0]                fsm_data_out,
  input  logic                       fsm_done,
  output logic                       frame_done,
  output logic                       err
);

  localparam int AW      = $clog2(N_BYTES);
  localparam int WW      = AW - 1;
  localparam int N_WORDS = N_BYTES / 2;

  localparam logic [AW-1:0] LAST_BYTE = AW'(N_BYTES - 1);
  localparam logic [WW-1:0] LAST_WORD = WW'(N_WORDS - 1);
  localparam logic [7:0]    TMO       = 8'(DONE_TIMEOUT);

  typedef enum logic [2:0] {
    S_LOAD,
    S_FLUSH,
    S_START,
    S_WAIT,
    S_RD_ADDR,
    S_RD_CAP,
    S_PRESENT,
    S_ERR
  } state_t;

  state_t          r_state;
  state_t          w_next;

  logic [AW-1:0]   r_bcnt;
  logic [WW-1:0]   r_widx;
  logic [7:0]      r_tcnt;
  logic            r_out_valid;
  logic [15:0]     r_out_data;
  logic            r_wr_en;
  logic [AW-1:0]   r_wr_add;
  logic [7:0]      r_data_wr;
  logic            r_op_mode;
  logic [WW-1:0]   r_rd_add;
  logic            r_err;

  logic            w_in_ready;
  logic            w_accept;
  logic            w_out_hs;
  logic            w_last_byte;
  logic            w_last_word;
  logic            w_timeout;

  // abort masks both handshakes so it wins over any transfer on the same edge
  assign w_in_ready  = (r_state == S_LOAD);
  assign w_accept    = w_in_ready && in_valid && !abort;
  assign w_out_hs    = (r_state == S_PRESENT) && out_ready && !abort;
  assign w_last_byte = (r_bcnt == LAST_BYTE);
  assign w_last_word = (r_widx == LAST_WORD);
  assign w_timeout   = (r_tcnt == TMO);

  always_comb begin
    w_next = r_state;
    if (abort) begin
      w_next = S_LOAD;
    end else begin
      case (r_state)
        S_LOAD:    if (w_accept && w_last_byte) w_next = S_FLUSH;
        S_FLUSH:   w_next = S_START;
        S_START:   w_next = S_WAIT;
        S_WAIT: begin
          if (fsm_done)       w_next = S_RD_ADDR;
          else if (w_timeout) w_next = S_ERR;
        end
        S_RD_ADDR: w_next = S_RD_CAP;
        S_RD_CAP:  w_next = S_PRESENT;
        S_PRESENT: begin
          if (out_ready) w_next = w_last_word ? S_LOAD : S_RD_ADDR;
        end
        S_ERR:     w_next = S_ERR;
        default:   w_next = S_LOAD;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_LOAD;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bcnt      <= '0;
      r_widx      <= '0;
      r_tcnt      <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_wr_en     <= 1'b0;
      r_wr_add    <= '0;
      r_data_wr   <= '0;
      r_op_mode   <= 1'b0;
      r_rd_add    <= '0;
      r_err       <= 1'b0;
    end else if (abort) begin
      r_bcnt      <= '0;
      r_widx      <= '0;
      r_tcnt      <= '0;
      r_out_valid <= 1'b0;
      r_wr_en     <= 1'b0;
      r_op_mode   <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      // Write port: the strobe trails the accepted byte by one cycle, so the
      // final write lands in FLUSH and never coincides with op_mode in START.
      r_wr_en   <= w_accept;
      r_op_mode <= (r_state == S_FLUSH);
      if (w_accept) begin
        r_wr_add  <= r_bcnt;
        r_data_wr <= in_data;
        r_bcnt    <= r_bcnt + 1'b1;
      end

      if (r_state == S_WAIT) begin
        r_tcnt <= r_tcnt + 1'b1;
      end else begin
        r_tcnt <= '0;
      end

      if ((r_state == S_WAIT) && !fsm_done && w_timeout) begin
        r_err <= 1'b1;
      end

      // Read port: the address is registered on entry to RD_ADDR so the
      // datapath's one-edge read latency lands its word in RD_CAP.
      if ((r_state == S_WAIT) && fsm_done) begin
        r_widx   <= '0;
        r_rd_add <= '0;
      end

      if (r_state == S_RD_CAP) begin
        r_out_data  <= fsm_data_out;
        r_out_valid <= 1'b1;
      end

      if (w_out_hs) begin
        r_out_valid <= 1'b0;
        if (w_last_word) begin
          r_widx <= '0;
          r_bcnt <= '0;
        end else begin
          r_widx   <= r_widx + 1'b1;
          r_rd_add <= r_widx + 1'b1;
        end
      end
    end
  end

  assign in_ready    = w_in_ready;
  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign fsm_wr_en   = r_wr_en;
  assign fsm_wr_add  = r_wr_add;
  assign fsm_data_wr = r_data_wr;
  assign fsm_op_mode = r_op_mode;
  assign fsm_rd_add  = r_rd_add;
  assign frame_done  = w_out_hs && w_last_word;
  assign err         = r_err;

endmodule

// File: tb/tb_xfer_sequencer.sv
// Bench for xfer_sequencer: behavioural datapath stub, byte producer, stalling
// word consumer and a scoreboard of expected packed words.
module tb_xfer_sequencer;

  localparam int N_BYTES      = 32;
  localparam int N_WORDS      = N_BYTES / 2;
  localparam int DONE_TIMEOUT = 255;

  logic        clk;
  logic        rst_n;
  logic        abort;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready;
  logic        fsm_wr_en;
  logic [4:0]  fsm_wr_add;
  logic [7:0]  fsm_data_wr;
  logic        fsm_op_mode;
  logic [3:0]  fsm_rd_add;
  logic [15:0] fsm_data_out;
  logic        fsm_done;
  logic        frame_done;
  logic        err;

  xfer_sequencer #(
    .N_BYTES      (N_BYTES),
    .DONE_TIMEOUT (DONE_TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .abort        (abort),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .fsm_wr_en    (fsm_wr_en),
    .fsm_wr_add   (fsm_wr_add),
    .fsm_data_wr  (fsm_data_wr),
    .fsm_op_mode  (fsm_op_mode),
    .fsm_rd_add   (fsm_rd_add),
    .fsm_data_out (fsm_data_out),
    .fsm_done     (fsm_done),
    .frame_done   (frame_done),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [15:0] word;
    logic        last;
    logic        mask_hi;
  } exp_t;

  exp_t sb[$];

  // Datapath stub: byte RAM, registered word read, done after a short delay
  logic [7:0] dp_mem [N_BYTES];
  bit         dp_dead = 1'b0;
  int         dp_cnt;

  always @(posedge clk) begin
    if (fsm_wr_en) dp_mem[fsm_wr_add] <= fsm_data_wr;
    fsm_data_out <= {dp_mem[{fsm_rd_add, 1'b0}], dp_mem[{fsm_rd_add, 1'b1}]};
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_done <= 1'b0;
      dp_cnt   <= 0;
    end else begin
      if (fsm_wr_en) fsm_done <= 1'b0;
      if (fsm_op_mode && !dp_dead) begin
        dp_cnt <= 4;
      end else if (dp_cnt != 0) begin
        dp_cnt <= dp_cnt - 1;
        if (dp_cnt == 1) fsm_done <= 1'b1;
      end
    end
  end

  // Consumer: after out_valid rises, hold out_ready low stall_cfg cycles
  bit cons_en   = 1'b1;
  int stall_cfg = 0;
  int stall_cnt = 0;

  always @(posedge clk) begin
    #1;
    if (out_valid && cons_en) begin
      if (stall_cnt < stall_cfg) begin
        out_ready = 1'b0;
        stall_cnt++;
      end else begin
        out_ready = 1'b1;
      end
    end else begin
      out_ready = 1'b0;
      stall_cnt = 0;
    end
  end

  int         cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [4:0] exp_wadd = '0;
  int         clr_req = 0;
  int         clr_seen = 0;
  int         wr_first_cyc = 0;
  int         wr_last_cyc = 0;
  int         opm_total = 0;
  int         overlap_cnt = 0;
  int         hs_cnt = 0;
  logic [15:0] held;
  bit         held_v = 1'b0;
  bit         prev_fd = 1'b0;

  always @(negedge clk) begin
    if (clr_seen != clr_req) begin
      exp_wadd = '0;
      clr_seen = clr_req;
    end
    if (!rst_n) begin
      held_v  = 1'b0;
      prev_fd = 1'b0;
    end else begin
      if (fsm_wr_en) begin
        chk_eq("wr_add", fsm_wr_add, exp_wadd);
        if (exp_wadd == 5'd0)  wr_first_cyc = cyc;
        if (exp_wadd == 5'd31) wr_last_cyc = cyc;
        exp_wadd = exp_wadd + 1'b1;
      end
      if (fsm_op_mode) opm_total++;
      if (fsm_op_mode && fsm_wr_en) overlap_cnt++;

      if (prev_fd) chk_eq("in_ready_after_frame_done", in_ready, 1'b1);
      prev_fd = frame_done;

      if (out_valid) begin
        if (held_v) chk_eq("out_data_stable", out_data, held);
        held   = out_data;
        held_v = 1'b1;
      end else begin
        held_v = 1'b0;
      end

      if (out_valid && out_ready) begin
        hs_cnt++;
        held_v = 1'b0;
        if (sb.size() == 0) begin
          chk_eq("sb_underflow", 32'd1, 32'd0);
        end else begin
          exp_t e;
          logic [15:0] got;
          e   = sb.pop_front();
          got = out_data;
          if (e.mask_hi) begin
            got[15:8]    = 8'h00;
            e.word[15:8] = 8'h00;
          end
          chk_eq("word", got, e.word);
          chk_eq("frame_done", frame_done, e.last);
        end
      end else if (frame_done) begin
        chk_eq("frame_done_spurious", frame_done, 1'b0);
      end
    end
  end

  task automatic push_byte(input logic [7:0] b, input bit gaps);
    int t;
    if (gaps) begin
      while ($urandom_range(0, 1) == 0) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    while (!in_ready && t < 3000) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 3000) chk_eq("in_ready_timeout", in_ready, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input logic [7:0] bytes [N_BYTES], input bit gaps, input bit push);
    for (int i = 0; i < N_BYTES; i++) push_byte(bytes[i], gaps);
    in_valid = 1'b0;
    if (push) begin
      for (int w = 0; w < N_WORDS; w++) begin
        exp_t e;
        e.word    = {bytes[2*w], bytes[2*w+1]};
        e.last    = (w == N_WORDS - 1);
        e.mask_hi = (w == 0);
        sb.push_back(e);
      end
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 3000) begin
      @(posedge clk);
      t++;
    end
    chk_eq("drain", sb.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  logic [7:0] fr [N_BYTES];
  int         opm0;
  int         hs0;
  int         n;
  int         t;

  initial begin
    rst_n     = 1'b0;
    abort     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    chk_eq("rst_in_ready",   in_ready,    1'b1);
    chk_eq("rst_out_valid",  out_valid,   1'b0);
    chk_eq("rst_out_data",   out_data,    16'h0000);
    chk_eq("rst_rd_add",     fsm_rd_add,  4'd0);
    chk_eq("rst_wr_en",      fsm_wr_en,   1'b0);
    chk_eq("rst_op_mode",    fsm_op_mode, 1'b0);
    chk_eq("rst_err",        err,         1'b0);
    chk_eq("rst_frame_done", frame_done,  1'b0);
    @(posedge clk); #1;

    // Streaming frame, in_valid held high, consumer always ready
    for (int i = 0; i < N_BYTES; i++) fr[i] = 8'(2*i + 1);
    opm0 = opm_total;
    send_frame(fr, 1'b0, 1'b1);
    drain();
    chk_eq("t1_wr_span", wr_last_cyc - wr_first_cyc, 31);
    chk_eq("t1_op_mode_cycles", opm_total - opm0, 1);

    // Random input gaps, 5-cycle output stalls
    stall_cfg = 5;
    opm0 = opm_total;
    send_frame(fr, 1'b1, 1'b1);
    drain();
    chk_eq("t2_op_mode_cycles", opm_total - opm0, 1);
    stall_cfg = 0;

    // Done never arrives: timeout into ERR, cleared by abort
    dp_dead = 1'b1;
    for (int i = 0; i < N_BYTES; i++) fr[i] = 8'($urandom_range(0, 255));
    send_frame(fr, 1'b0, 1'b0);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!fsm_op_mode && t < 20);
    chk_eq("t3_op_mode_seen", fsm_op_mode, 1'b1);
    n = 0;
    while (n < 1000) begin
      @(negedge clk);
      if (err) break;
      n++;
    end
    chk_eq("t3_timeout_cycles", n, DONE_TIMEOUT + 1);
    chk_eq("t3_err", err, 1'b1);
    chk_eq("t3_in_ready", in_ready, 1'b0);
    chk_eq("t3_out_valid", out_valid, 1'b0);
    repeat (3) @(negedge clk);
    chk_eq("t3_err_sticky", err, 1'b1);
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    clr_req++;
    @(negedge clk);
    chk_eq("t3_err_cleared", err, 1'b0);
    chk_eq("t3_in_ready_after_abort", in_ready, 1'b1);
    dp_dead = 1'b0;
    @(posedge clk); #1;

    // Partial frame aborted (abort collides with a valid byte), then full frame
    for (int i = 0; i < 10; i++) push_byte(8'(8'hF0 + i), 1'b0);
    in_valid = 1'b1;
    in_data  = 8'h55;
    abort    = 1'b1;
    @(posedge clk); #1;
    abort    = 1'b0;
    in_valid = 1'b0;
    clr_req++;
    @(negedge clk);
    chk_eq("t4_no_write_after_abort", fsm_wr_en, 1'b0);
    @(posedge clk); #1;
    for (int i = 0; i < N_BYTES; i++) fr[i] = 8'(8'hA0 + i);
    send_frame(fr, 1'b0, 1'b1);
    drain();

    // Asynchronous reset while word 7 is being presented
    stall_cfg = 2;
    hs0 = hs_cnt;
    for (int i = 0; i < N_BYTES; i++) fr[i] = 8'(8'h40 + 3*i);
    send_frame(fr, 1'b0, 1'b1);
    t = 0;
    while (hs_cnt - hs0 < 7 && t < 2000) begin
      @(negedge clk); #1;
      t++;
    end
    chk_eq("t5_words_before_reset", hs_cnt - hs0, 7);
    cons_en = 1'b0;
    t = 0;
    do begin
      @(negedge clk); #1;
      t++;
    end while (!out_valid && t < 20);
    chk_eq("t5_word7_presented", out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_eq("t5_out_valid_reset", out_valid, 1'b0);
    chk_eq("t5_frame_done_reset", frame_done, 1'b0);
    chk_eq("t5_out_data_reset", out_data, 16'h0000);
    sb.delete();
    clr_req++;
    @(posedge clk); #1;
    rst_n     = 1'b1;
    cons_en   = 1'b1;
    stall_cfg = 0;
    @(posedge clk); #1;
    for (int i = 0; i < N_BYTES; i++) fr[i] = 8'($urandom_range(0, 255));
    send_frame(fr, 1'b0, 1'b1);
    drain();

    // Two frames back to back
    opm0 = opm_total;
    for (int i = 0; i < N_BYTES; i++) fr[i] = 8'(8'hFF - i);
    send_frame(fr, 1'b0, 1'b1);
    for (int i = 0; i < N_BYTES; i++) fr[i] = 8'($urandom_range(0, 255));
    send_frame(fr, 1'b0, 1'b1);
    drain();
    chk_eq("t6_op_mode_cycles", opm_total - opm0, 2);

    chk_eq("wr_en_op_mode_overlap", overlap_cnt, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
